// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock FIFO with registered status flags, occupancy count, read-valid
//   strobe and sticky overflow/underflow error flags.
//
//   Handshake: a write is taken on a rising edge when wr_en is high and the FIFO
//   is not full, or when it is full but a read is taken in the same cycle.
//   A read is taken when rd_en is high and the FIFO is not empty. Requests that
//   are not taken are dropped and latch the matching sticky error flag.
//
//   Optional feature macro: SYNC_FIFO_FWFT_EN
//     defined   : first-word-fall-through, rd_data shows the head word
//                 continuously, rd_valid = ~empty, rd_en pops the head.
//     undefined : registered read, rd_data/rd_valid update one cycle after a
//                 taken read.
//
//   Ports
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     wr_en, wr_data      write request and data
//     rd_en               read request (pop acknowledge in FWFT mode)
//     rd_data, rd_valid   read data and its valid strobe
//     full, empty         count == FIFO_DEPTH / count == 0
//     almost_full         count >= AFULL_LVL
//     almost_empty        count <= AEMPTY_LVL
//     fifo_cnt            occupancy 0..FIFO_DEPTH
//     overflow, underflow sticky error flags
//     clr_err             synchronous clear of the error flags
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    rd_acc   = rd_en & ~empty_q;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc   = wr_en & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Flags come from the next count so they are exact right after the edge.
    full_d   = (cnt_d == DEPTH_C);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= AFULL_C);
    aempty_d = (cnt_d <= AEMPTY_C);

    // Set terms are ORed after the clear so a same-cycle set wins.
    ovf_d = (ovf_q & ~clr_err) | (wr_en & full_q & ~rd_acc);
    unf_d = (unf_q & ~clr_err) | (rd_en & empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem_q[rd_ptr_q];
  assign rd_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  // The read port samples the old word even when a write hits the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//   Directed bench for sync_fifo_flags: a 16-deep instance for the main
//   sequence and a 6-deep instance for a wrap-around stress run against a
//   reference queue. Prints one summary line at the end.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 16-deep instance ----------------
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] fifo_cnt;

  sync_fifo_flags #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4), .AFULL_LVL(12), .AEMPTY_LVL(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  // ---------------- 6-deep instance ----------------
  logic       w6_en = 1'b0, r6_en = 1'b0, c6_clr = 1'b0;
  logic [7:0] w6_data = '0;
  logic [7:0] r6_data;
  logic       r6_valid, f6_full, f6_empty, f6_afull, f6_aempty, f6_ovf, f6_unf;
  logic [3:0] f6_cnt;

  sync_fifo_flags #(
    .DATA_WIDTH(8), .FIFO_DEPTH(6), .ADDR_WIDTH(3), .AFULL_LVL(5), .AEMPTY_LVL(1)
  ) u_dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(w6_en), .wr_data(w6_data), .rd_en(r6_en),
    .rd_data(r6_data), .rd_valid(r6_valid), .full(f6_full), .empty(f6_empty),
    .almost_full(f6_afull), .almost_empty(f6_aempty), .fifo_cnt(f6_cnt),
    .overflow(f6_ovf), .underflow(f6_unf), .clr_err(c6_clr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp6_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- drivers ----------------
  // Apply one cycle of requests, sample #1 after the edge, then idle inputs.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic step6(input logic we, input logic [7:0] wd, input logic re);
    w6_en = we; w6_data = wd; r6_en = re;
    @(posedge clk); #1;
    w6_en = 1'b0; r6_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    int         m_cnt;
    logic       we, re, racc, wacc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_valid", rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_rdata", rd_data, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef SYNC_FIFO_FWFT_EN
    // 1. fill 0x01..0x10, then one dropped write
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_cnt", fifo_cnt, i);
      chk("fill_full", full, (i == 16));
      chk("fill_afull", almost_full, (i >= 12));
      chk("fill_aempty", almost_empty, (i <= 4));
      chk("fill_empty", empty, 0);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("ovf_cnt", fifo_cnt, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 1);

    // 2. drain in order, then one read of an empty FIFO
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_valid", rd_valid, 1);
      chk("drain_data", rd_data, i);
      chk("drain_cnt", fifo_cnt, 16 - i);
      chk("drain_empty", empty, (i == 16));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", rd_valid, 0);
    chk("idle_data_hold", rd_data, 8'h10);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_flag", underflow, 1);
    chk("unf_valid", rd_valid, 0);
    chk("unf_data_hold", rd_data, 8'h10);
    chk("unf_keeps_ovf", overflow, 1);

    // 5a. set beats clear, then plain clear
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("setwins_unf", underflow, 1);
    chk("setwins_ovf_clr", overflow, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_unf", underflow, 0);
    chk("clr_ovf", overflow, 0);

    // 3. full with simultaneous push/pop across the pointer wrap
    for (int i = 0; i < 16; i++) begin
      v = 8'h20 + 8'(i);
      step(1'b1, v, 1'b0, 1'b0);
      exp_q.push_back(v);
    end
    chk("full2_cnt", fifo_cnt, 16);
    for (int k = 0; k < 20; k++) begin
      v = 8'h40 + 8'(k);
      exp_q.push_back(v);
      step(1'b1, v, 1'b1, 1'b0);
      chk("both_data", rd_data, exp_q.pop_front());
      chk("both_valid", rd_valid, 1);
      chk("both_cnt", fifo_cnt, 16);
      chk("both_ovf", overflow, 0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain2_data", rd_data, exp_q.pop_front());
    end
    chk("drain2_empty", empty, 1);

    // empty with push and pop together: write kept, read dropped
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("ewr_cnt", fifo_cnt, 1);
    chk("ewr_unf", underflow, 1);
    chk("ewr_valid", rd_valid, 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ewr_clr", underflow, 0);

    // 5b. asynchronous reset with 7 words stored
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("pre_rst_cnt", fifo_cnt, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", fifo_cnt, 0);
    chk("arst_empty", empty, 1);
    chk("arst_aempty", almost_empty, 1);
    chk("arst_afull", almost_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4. random push/pop on the 6-deep instance
    m_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      we   = ($urandom_range(0, 99) < 60);
      re   = ($urandom_range(0, 99) < 50);
      v    = 8'($urandom_range(0, 255));
      racc = re && (m_cnt > 0);
      wacc = we && ((m_cnt < 6) || racc);
      step6(we, v, re);
      if (racc) begin
        chk("r6_valid", r6_valid, 1);
        chk("r6_data", r6_data, exp6_q.pop_front());
      end else begin
        chk("r6_novalid", r6_valid, 0);
      end
      if (wacc) exp6_q.push_back(v);
      m_cnt = m_cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
      chk("r6_cnt", f6_cnt, m_cnt);
      chk("r6_full", f6_full, (m_cnt == 6));
      chk("r6_aempty", f6_aempty, (m_cnt <= 1));
    end
`else
    // 6. first-word-fall-through
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_data", rd_data, 8'hA5);
    chk("fwft_valid", rd_valid, 1);
    chk("fwft_cnt", fifo_cnt, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", empty, 1);
    chk("fwft_pop_valid", rd_valid, 0);
    chk("fwft_pop_cnt", fifo_cnt, 0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("fwft_head1", rd_data, 8'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_head2", rd_data, 8'hC3);
    chk("fwft_cnt2", fifo_cnt, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("fwft_ewr_unf", underflow, 1);
    chk("fwft_ewr_cnt", fifo_cnt, 1);
    chk("fwft_ewr_data", rd_data, 8'h5A);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
